// File: rtl/id_ex_pkg.sv
// Shared types for the ID/EX skid register: slot state encoding, default widths,
// the default-width slot layout and the bubble control value.
package id_ex_pkg;

    localparam int DATA_W_DEF = 128;
    localparam int CTRL_W_DEF = 16;
    localparam int REG_W_DEF  = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    // Slot layout at default widths; parameterised instances declare the same field order locally.
    typedef struct packed {
        logic [REG_W_DEF-1:0]  rs1;
        logic [REG_W_DEF-1:0]  rs2;
        logic [REG_W_DEF-1:0]  rd;
        logic                  mem_rd;
        logic [CTRL_W_DEF-1:0] ctrl;
        logic [DATA_W_DEF-1:0] data;
    } slot_t;

    localparam logic [CTRL_W_DEF-1:0] NOP_CTRL = '0;

endpackage

// File: rtl/id_ex_hazard_cmp.sv
// Load-use comparator: flags an incoming consumer of the load currently held in EX.
// Only instantiated when ID_EX_LOAD_USE_EN is defined.
module id_ex_hazard_cmp
    import id_ex_pkg::*;
#(
    parameter int REG_W = REG_W_DEF
) (
    input  logic             i_in_valid,
    input  logic             i_out_valid,
    input  logic             i_out_mem_rd,
    input  logic [REG_W-1:0] i_out_rd,
    input  logic [REG_W-1:0] i_in_rs1,
    input  logic [REG_W-1:0] i_in_rs2,
    output logic             o_hz
);

    logic w_rd_nonzero;
    logic w_rd_match;

    // x0 is hardwired, so a load targeting it never creates a dependency.
    assign w_rd_nonzero = (i_out_rd != '0);
    assign w_rd_match   = (i_out_rd == i_in_rs1) | (i_out_rd == i_in_rs2);
    assign o_hz         = i_in_valid & i_out_valid & i_out_mem_rd & w_rd_nonzero & w_rd_match;

endmodule

// File: rtl/id_ex_skid_reg.sv
// ID/EX pipeline register with valid/ready handshake, 2-entry skid buffer and flush.
// Optional load-use stall compiled in with `define ID_EX_LOAD_USE_EN.
module id_ex_skid_reg
    import id_ex_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int CTRL_W = CTRL_W_DEF,
    parameter int REG_W  = REG_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [REG_W-1:0]  in_rs1,
    input  logic [REG_W-1:0]  in_rs2,
    input  logic [REG_W-1:0]  in_rd,
    input  logic              in_mem_rd,
    input  logic [CTRL_W-1:0] in_ctrl,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [REG_W-1:0]  out_rs1,
    output logic [REG_W-1:0]  out_rs2,
    output logic [REG_W-1:0]  out_rd,
    output logic              out_mem_rd,
    output logic [CTRL_W-1:0] out_ctrl,
    output logic [DATA_W-1:0] out_data,
    output logic              hazard_stall,
    output logic [1:0]        dbg_state
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // valid never waits on ready, and in_ready depends only on registered state (plus the load-use compare).
    typedef struct packed {
        logic [REG_W-1:0]  rs1;
        logic [REG_W-1:0]  rs2;
        logic [REG_W-1:0]  rd;
        logic              mem_rd;
        logic [CTRL_W-1:0] ctrl;
        logic [DATA_W-1:0] data;
    } entry_t;

    state_t r_state;
    state_t w_state_nxt;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;
    logic   w_out_valid;
    logic   w_in_ready;
    logic   w_in_fire;
    logic   w_hz;
    logic   w_load_main;
    logic   w_load_skid;
    logic   w_main_from_skid;

    assign w_in_entry = '{rs1: in_rs1, rs2: in_rs2, rd: in_rd, mem_rd: in_mem_rd,
                          ctrl: in_ctrl, data: in_data};

`ifdef ID_EX_LOAD_USE_EN
    id_ex_hazard_cmp #(
        .REG_W(REG_W)
    ) u_hazard_cmp (
        .i_in_valid  (in_valid),
        .i_out_valid (w_out_valid),
        .i_out_mem_rd(r_main.mem_rd),
        .i_out_rd    (r_main.rd),
        .i_in_rs1    (in_rs1),
        .i_in_rs2    (in_rs2),
        .o_hz        (w_hz)
    );
`else
    assign w_hz = 1'b0;
`endif

    assign w_out_valid = (r_state != EMPTY);
    assign w_in_ready  = ~reset & (r_state != FULL) & ~w_hz;
    assign w_in_fire   = in_valid & w_in_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_load_main      = 1'b0;
        w_load_skid      = 1'b0;
        w_main_from_skid = 1'b0;
        if (flush) begin
            w_state_nxt = EMPTY;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_state_nxt = BUSY;
                        w_load_main = 1'b1;
                    end
                end
                BUSY: begin
                    if (w_in_fire && out_ready) begin
                        w_load_main = 1'b1;
                    end else if (w_in_fire) begin
                        w_state_nxt = FULL;
                        w_load_skid = 1'b1;
                    end else if (out_ready) begin
                        w_state_nxt = EMPTY;
                    end
                end
                FULL: begin
                    // The skid entry is older than anything upstream, so it refills main first.
                    if (out_ready) begin
                        w_state_nxt      = BUSY;
                        w_load_main      = 1'b1;
                        w_main_from_skid = 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Flush only clears occupancy; payload and ids stay put for downstream debug visibility.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_main <= '0;
            r_skid <= '0;
        end else begin
            if (w_load_main) begin
                r_main <= w_main_from_skid ? r_skid : w_in_entry;
            end
            if (w_load_skid) begin
                r_skid <= w_in_entry;
            end
        end
    end

    assign in_ready     = w_in_ready;
    assign out_valid    = w_out_valid;
    assign out_rs1      = r_main.rs1;
    assign out_rs2      = r_main.rs2;
    assign out_rd       = r_main.rd;
    assign out_mem_rd   = r_main.mem_rd & w_out_valid;
    assign out_ctrl     = w_out_valid ? r_main.ctrl : CTRL_W'(NOP_CTRL);
    assign out_data     = r_main.data;
    assign hazard_stall = w_hz;
    assign dbg_state    = r_state;

endmodule
